fifo_write_arbiter: RTL

Round-robin arbiter that shares the single write port of the dual-clock `fifo_memory` between `NUM_REQ` producers in the write-clock domain. It drives `din_a`/`wen_a`, honours `full`, and grants bounded bursts so that no producer can monopolise the FIFO. It sits directly in front of `fifo_memory` on the `clk_a` side; the read side is untouched.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/rr_pick.sv | 33 +++
 rtl/fifo_write_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO and the logic around its ports.
// Width and depth defaults match fifo_memory.
package fifo_pkg;

    localparam int FIFO_WIDTH   = 16;
    localparam int FIFO_DEPTH   = 16;
    localparam int ADDRESS_SIZE = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: returns the first set request at or above ptr, wrapping.
// Purely combinational so it can also serve a future read-side scheduler.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_idx;
        // NOTE: every output and temporary gets a default before any branch, so no latch is inferred.
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        // Scan from farthest to nearest so the lowest rotation distance wins last.
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            cand_idx = ID_W'(cand);
            if (req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the fifo_memory write port between NUM_REQ producers,
// granting bounded bursts so no producer can monopolise the FIFO.
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8,
    parameter int REQ_ID_W   = $clog2(NUM_REQ)
) (
    input  logic                          clk_a,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic [FIFO_WIDTH-1:0]         din_a,
    output logic                          wen_a,
    output logic [REQ_ID_W-1:0]           grant_id,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t          state, state_nxt;
    logic [REQ_ID_W-1:0] owner, owner_nxt;
    logic [REQ_ID_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]    burst_cnt, burst_cnt_nxt;

    logic                pick_found;
    logic [REQ_ID_W-1:0] pick_idx;
    logic                owner_valid;
    logic                burst_last;
    logic [REQ_ID_W-1:0] ptr_after_owner;

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (REQ_ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Data mux follows owner in every state; owner is 0 after reset.
    always_comb begin
        din_a = req_data[FIFO_WIDTH-1:0];
        for (int i = 1; i < NUM_REQ; i++) begin
            if (owner == REQ_ID_W'(i)) din_a = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    assign owner_valid     = req_valid[owner];
    assign busy            = (state == BUSY);
    assign grant_id        = owner;
    // full gates the write port combinationally so the cycle full rises is already safe.
    assign wen_a           = busy & owner_valid & ~full;
    assign req_ready       = (busy && !full) ? (NUM_REQ'(1) << owner) : '0;
    assign burst_last      = (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign ptr_after_owner = (owner == REQ_ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt     = BUSY;
                    owner_nxt     = pick_idx;
                    burst_cnt_nxt = '0;
                end
            end
            BUSY: begin
                // An idle owner releases even while full; otherwise full freezes the burst.
                if (!owner_valid || (wen_a && burst_last)) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = ptr_after_owner;
                end else if (wen_a) begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk_a) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

endmodule
